// File: rtl/fetch_redirect_unit_if.sv
// IF-stage boundary bundle: branch decision and stall from ID/hazard logic in,
// fetch address and IF/ID pipeline register contents out.
interface fetch_redirect_unit_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   PCSrc;
  logic [PC_WIDTH-1:0]    BranchTarget;
  logic                   Stall;
  logic [INSTR_WIDTH-1:0] Instr_in;
  logic [PC_WIDTH-1:0]    PC;
  logic [INSTR_WIDTH-1:0] IF_ID_Instr;
  logic [PC_WIDTH-1:0]    IF_ID_PC4;
  logic                   IF_ID_Valid;
  logic                   Halted;
  logic [15:0]            BranchCount;

  // Pipeline/control side that drives the fetch unit
  modport master (
    output PCSrc, BranchTarget, Stall, Instr_in,
    input  PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Halted, BranchCount
  );

  // Fetch unit itself
  modport slave (
    input  PCSrc, BranchTarget, Stall, Instr_in,
    output PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Halted, BranchCount
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF stage: PC register, IF/ID register, taken-branch redirect with flush,
// halt-word drain sequence and a saturating redirect counter.
module fetch_redirect_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          INSTR_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned          DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_redirect_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t                 state_r;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [INSTR_WIDTH-1:0] if_id_instr_r;
  logic [PC_WIDTH-1:0]    if_id_pc4_r;
  logic                   if_id_valid_r;
  logic                   halted_r;
  logic [15:0]            branch_count_r;
  logic [3:0]             drain_cnt_r;

  logic [PC_WIDTH-1:0]    pc_plus4_s;
  logic [15:0]            branch_count_next_s;
  logic                   halt_fetch_s;

  // Next-value helpers: wrapping PC+4, saturating redirect count, halt decode
  always_comb begin
    pc_plus4_s   = pc_r + PC_WIDTH'(4);
    halt_fetch_s = (bus.Instr_in == HALT_WORD);
    if (branch_count_r == 16'hFFFF) begin
      branch_count_next_s = branch_count_r;
    end else begin
      branch_count_next_s = branch_count_r + 16'd1;
    end
  end

  // Fetch FSM: PC, IF/ID register, drain countdown, halt flag and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_RUN;
      pc_r           <= RESET_PC;
      if_id_instr_r  <= {INSTR_WIDTH{1'b0}};
      if_id_pc4_r    <= {PC_WIDTH{1'b0}};
      if_id_valid_r  <= 1'b0;
      halted_r       <= 1'b0;
      branch_count_r <= 16'd0;
      drain_cnt_r    <= DRAIN_INIT;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.Stall) begin
            // Branch operands are not resolved while stalled, so PCSrc is not trusted
            pc_r <= pc_r;
          end else if (bus.PCSrc) begin
            pc_r           <= bus.BranchTarget;
            if_id_instr_r  <= {INSTR_WIDTH{1'b0}};
            if_id_pc4_r    <= {PC_WIDTH{1'b0}};
            if_id_valid_r  <= 1'b0;
            branch_count_r <= branch_count_next_s;
          end else begin
            if_id_instr_r <= bus.Instr_in;
            if_id_pc4_r   <= pc_plus4_s;
            if_id_valid_r <= 1'b1;
            if (halt_fetch_s) begin
              state_r     <= ST_DRAIN;
              drain_cnt_r <= DRAIN_INIT;
            end else begin
              pc_r <= pc_plus4_s;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.Stall) begin
            drain_cnt_r <= drain_cnt_r;
          end else begin
            if_id_instr_r <= {INSTR_WIDTH{1'b0}};
            if_id_pc4_r   <= {PC_WIDTH{1'b0}};
            if_id_valid_r <= 1'b0;
            drain_cnt_r   <= drain_cnt_r - 4'd1;
            // Counter lands on zero this edge; a corrupted zero also terminates
            if (drain_cnt_r <= 4'd1) begin
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
            end else begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_HALTED: begin
          halted_r      <= 1'b1;
          if_id_valid_r <= 1'b0;
        end
        default: begin
          state_r       <= ST_HALTED;
          halted_r      <= 1'b1;
          if_id_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC          = pc_r;
  assign bus.IF_ID_Instr = if_id_instr_r;
  assign bus.IF_ID_PC4   = if_id_pc4_r;
  assign bus.IF_ID_Valid = if_id_valid_r;
  assign bus.Halted      = halted_r;
  assign bus.BranchCount = branch_count_r;

endmodule
